// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Branch resolution and squash stage. Evaluates the branch
//               condition against the DSP48E1 result (or the raw rs operand),
//               issues a one-cycle PC redirect on a taken branch, squashes the
//               younger in-flight instructions for FLUSH_DEPTH cycles, forwards
//               squash-gated write-back controls and keeps a saturating count
//               of taken branches.
// Ports       :
//   clk, rst                 clock, synchronous active-high reset
//   valid_i                  instruction at the inputs is valid
//   branchen_i               instruction is a branch/jump
//   branchtype_i[2:0]        condition code
//   branchtarget_i[15:0]     target PC
//   cmpsel_i                 1: compare alu_result_i, 0: compare rs_data_i
//   alu_result_i, rs_data_i  compare operands
//   rd_addr_i, regwrite_i, regwriteui_i, regwritehilo_i  write-back controls
//   pc_redirect_o            one-cycle redirect pulse
//   pc_target_o[15:0]        redirect target (held between redirects)
//   flush_o                  squash window active
//   rd_addr_o, regwrite_o, regwriteui_o, regwritehilo_o  registered write-back
//   taken_count_o[15:0]      saturating taken-branch count
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int FLUSH_DEPTH = 3,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  branchen_i,
    input  logic [2:0]            branchtype_i,
    input  logic [15:0]           branchtarget_i,
    input  logic                  cmpsel_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [4:0]            rd_addr_i,
    input  logic                  regwrite_i,
    input  logic                  regwriteui_i,
    input  logic [1:0]            regwritehilo_i,
    output logic                  pc_redirect_o,
    output logic [15:0]           pc_target_o,
    output logic                  flush_o,
    output logic [4:0]            rd_addr_o,
    output logic                  regwrite_o,
    output logic                  regwriteui_o,
    output logic [1:0]            regwritehilo_o,
    output logic [15:0]           taken_count_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0]  S_IDLE      = 1'b0;
    localparam logic [0:0]  S_FLUSH     = 1'b1;

    localparam logic [2:0]  c_br_beq    = 3'b000;
    localparam logic [2:0]  c_br_bne    = 3'b001;
    localparam logic [2:0]  c_br_blez   = 3'b010;
    localparam logic [2:0]  c_br_bgtz   = 3'b011;
    localparam logic [2:0]  c_br_bltz   = 3'b100;
    localparam logic [2:0]  c_br_bgez   = 3'b101;
    localparam logic [2:0]  c_br_j      = 3'b110;

    localparam logic [3:0]  c_cnt_init  = 4'(FLUSH_DEPTH);
    localparam logic [15:0] c_count_max = 16'hFFFF;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_pc_redirect;
    logic [15:0] r_pc_target;
    logic [15:0] r_taken_count;
    logic [4:0]  r_rd_addr;
    logic        r_regwrite;
    logic        r_regwriteui;
    logic [1:0]  r_regwritehilo;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_cmp_val;
    logic                  w_zero;
    logic                  w_neg;
    logic                  w_cond;
    logic                  w_squash;
    logic                  w_taken;
    logic                  w_wb_pass;

    logic [0:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_redirect_nxt;
    logic [15:0] w_target_nxt;
    logic [15:0] w_count_nxt;

    // ------------------------------------------------------------------
    // Branch condition evaluation
    // ------------------------------------------------------------------
    assign w_cmp_val = cmpsel_i ? alu_result_i : rs_data_i;
    assign w_zero    = (w_cmp_val == '0);
    assign w_neg     = w_cmp_val[DATA_WIDTH-1];

    always_comb begin
        w_cond = 1'b0;
        case (branchtype_i)
            c_br_beq:  w_cond = w_zero;
            c_br_bne:  w_cond = ~w_zero;
            c_br_blez: w_cond = w_neg | w_zero;
            c_br_bgtz: w_cond = ~w_neg & ~w_zero;
            c_br_bltz: w_cond = w_neg;
            c_br_bgez: w_cond = ~w_neg;
            c_br_j:    w_cond = 1'b1;
            default:   w_cond = 1'b0;   // reserved encoding is never taken
        endcase
    end

    // The squash comes from the registered state only, so the branch that
    // opens a window is itself never squashed.
    assign w_squash  = (r_state == S_FLUSH);
    assign w_taken   = valid_i & branchen_i & w_cond & ~w_squash;
    assign w_wb_pass = valid_i & ~w_squash;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_taken) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            S_FLUSH: begin
                w_cnt_nxt = r_cnt - 4'd1;
                // cnt==1 on entry to this edge means this is the last
                // squashed cycle of the window.
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_redirect_nxt = 1'b0;
        w_target_nxt   = r_pc_target;
        w_count_nxt    = r_taken_count;
        if (w_taken) begin
            w_redirect_nxt = 1'b1;
            w_target_nxt   = branchtarget_i;
            if (r_taken_count != c_count_max) begin
                w_count_nxt = r_taken_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_redirect  <= 1'b0;
            r_pc_target    <= 16'd0;
            r_taken_count  <= 16'd0;
            r_rd_addr      <= 5'd0;
            r_regwrite     <= 1'b0;
            r_regwriteui   <= 1'b0;
            r_regwritehilo <= 2'b00;
        end else begin
            r_pc_redirect  <= w_redirect_nxt;
            r_pc_target    <= w_target_nxt;
            r_taken_count  <= w_count_nxt;
            r_rd_addr      <= rd_addr_i;
            r_regwrite     <= regwrite_i & w_wb_pass;
            r_regwriteui   <= regwriteui_i & w_wb_pass;
            r_regwritehilo <= regwritehilo_i & {2{w_wb_pass}};
        end
    end

    assign pc_redirect_o  = r_pc_redirect;
    assign pc_target_o    = r_pc_target;
    assign flush_o        = w_squash;
    assign taken_count_o  = r_taken_count;
    assign rd_addr_o      = r_rd_addr;
    assign regwrite_o     = r_regwrite;
    assign regwriteui_o   = r_regwriteui;
    assign regwritehilo_o = r_regwritehilo;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Directed self-checking bench for branch_resolve
//               (FLUSH_DEPTH=3, DATA_WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    localparam int FD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        branchen_i;
    logic [2:0]  branchtype_i;
    logic [15:0] branchtarget_i;
    logic        cmpsel_i;
    logic [31:0] alu_result_i;
    logic [31:0] rs_data_i;
    logic [4:0]  rd_addr_i;
    logic        regwrite_i;
    logic        regwriteui_i;
    logic [1:0]  regwritehilo_i;
    logic        pc_redirect_o;
    logic [15:0] pc_target_o;
    logic        flush_o;
    logic [4:0]  rd_addr_o;
    logic        regwrite_o;
    logic        regwriteui_o;
    logic [1:0]  regwritehilo_o;
    logic [15:0] taken_count_o;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    branch_resolve #(.FLUSH_DEPTH(FD), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .branchen_i     (branchen_i),
        .branchtype_i   (branchtype_i),
        .branchtarget_i (branchtarget_i),
        .cmpsel_i       (cmpsel_i),
        .alu_result_i   (alu_result_i),
        .rs_data_i      (rs_data_i),
        .rd_addr_i      (rd_addr_i),
        .regwrite_i     (regwrite_i),
        .regwriteui_i   (regwriteui_i),
        .regwritehilo_i (regwritehilo_i),
        .pc_redirect_o  (pc_redirect_o),
        .pc_target_o    (pc_target_o),
        .flush_o        (flush_o),
        .rd_addr_o      (rd_addr_o),
        .regwrite_o     (regwrite_o),
        .regwriteui_o   (regwriteui_o),
        .regwritehilo_o (regwritehilo_o),
        .taken_count_o  (taken_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i        = 1'b0;
        branchen_i     = 1'b0;
        branchtype_i   = 3'b000;
        branchtarget_i = 16'h0000;
        cmpsel_i       = 1'b0;
        alu_result_i   = 32'h1;
        rs_data_i      = 32'h1;
        rd_addr_i      = 5'd0;
        regwrite_i     = 1'b0;
        regwriteui_i   = 1'b0;
        regwritehilo_i = 2'b00;
    endtask

    task automatic set_br(input logic [2:0] ty, input logic sel, input logic [31:0] alu,
                          input logic [31:0] rs, input logic [15:0] tgt);
        valid_i        = 1'b1;
        branchen_i     = 1'b1;
        branchtype_i   = ty;
        cmpsel_i       = sel;
        alu_result_i   = alu;
        rs_data_i      = rs;
        branchtarget_i = tgt;
    endtask

    // Present one branch for a cycle, check whether it redirected, and let
    // any resulting squash window drain before returning.
    task automatic try_br(input string tag, input logic [2:0] ty, input logic sel,
                          input logic [31:0] alu, input logic [31:0] rs, input logic exp_tk);
        set_br(ty, sel, alu, rs, 16'h0123);
        tick();
        idle();
        chk({tag, "_redirect"}, 32'(pc_redirect_o), 32'(exp_tk));
        chk({tag, "_flush"}, 32'(flush_o), 32'(exp_tk));
        if (exp_tk) begin
            exp_count++;
            repeat (FD) tick();
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        regwrite_i = 1'b1; valid_i = 1'b1; rd_addr_i = 5'd9;
        tick(); tick();
        // ---------------- reset state ----------------
        chk("rst_redirect", 32'(pc_redirect_o), 32'd0);
        chk("rst_target",   32'(pc_target_o),   32'd0);
        chk("rst_flush",    32'(flush_o),       32'd0);
        chk("rst_count",    32'(taken_count_o), 32'd0);
        chk("rst_rd",       32'(rd_addr_o),     32'd0);
        chk("rst_rw",       32'(regwrite_o),    32'd0);
        idle();
        rst = 1'b0;
        tick();

        // ---------------- BEQ taken, link write passes ----------------
        set_br(3'b000, 1'b1, 32'h0, 32'h5, 16'h0040);
        regwrite_i = 1'b1; rd_addr_i = 5'd31;
        tick();                                   // t+1
        chk("beq_redirect", 32'(pc_redirect_o), 32'd1);
        chk("beq_target",   32'(pc_target_o),   32'h0040);
        chk("beq_flush1",   32'(flush_o),       32'd1);
        chk("beq_count",    32'(taken_count_o), 32'd1);
        chk("beq_link_rw",  32'(regwrite_o),    32'd1);
        chk("beq_link_rd",  32'(rd_addr_o),     32'd31);
        exp_count = 1;
        idle();
        valid_i = 1'b1; regwrite_i = 1'b1; regwriteui_i = 1'b1; regwritehilo_i = 2'b11;
        tick();                                   // t+2
        chk("beq_pulse_end", 32'(pc_redirect_o), 32'd0);
        chk("beq_target_hold", 32'(pc_target_o), 32'h0040);
        chk("beq_flush2",   32'(flush_o),       32'd1);
        chk("sq_rw2",       32'(regwrite_o),    32'd0);
        chk("sq_hilo2",     32'(regwritehilo_o), 32'd0);
        tick();                                   // t+3
        chk("beq_flush3",   32'(flush_o),       32'd1);
        chk("sq_rwui3",     32'(regwriteui_o),  32'd0);
        tick();                                   // t+4
        chk("beq_flush4",   32'(flush_o),       32'd0);
        chk("sq_rw4",       32'(regwrite_o),    32'd0);
        tick();                                   // t+5: input of t+4 not squashed
        chk("post_rw5",     32'(regwrite_o),    32'd1);
        chk("post_ui5",     32'(regwriteui_o),  32'd1);
        chk("post_hilo5",   32'(regwritehilo_o), 32'd3);
        idle();

        // ---------------- BNE not taken on zero ----------------
        set_br(3'b001, 1'b1, 32'h0, 32'h5, 16'h0080);
        regwrite_i = 1'b1; rd_addr_i = 5'd7;
        tick();
        idle();
        chk("bne_redirect", 32'(pc_redirect_o), 32'd0);
        chk("bne_flush",    32'(flush_o),       32'd0);
        chk("bne_rw",       32'(regwrite_o),    32'd1);
        chk("bne_rd",       32'(rd_addr_o),     32'd7);
        chk("bne_count",    32'(taken_count_o), 32'd1);

        // ---------------- sign / zero conditions ----------------
        try_br("bltz_neg", 3'b100, 1'b0, 32'h0, 32'h8000_0000, 1'b1);
        try_br("blez_neg", 3'b010, 1'b0, 32'h0, 32'h8000_0000, 1'b1);
        try_br("bgez_neg", 3'b101, 1'b0, 32'h0, 32'h8000_0000, 1'b0);
        try_br("bgtz_neg", 3'b011, 1'b0, 32'h0, 32'h8000_0000, 1'b0);
        try_br("bgez_zero", 3'b101, 1'b0, 32'h8000_0000, 32'h0, 1'b1);
        try_br("blez_zero", 3'b010, 1'b0, 32'h8000_0000, 32'h0, 1'b1);
        try_br("bgtz_zero", 3'b011, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
        try_br("bgtz_pos",  3'b011, 1'b0, 32'h0, 32'h0000_0005, 1'b1);
        try_br("bltz_alu",  3'b100, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
        try_br("rsv_zero",  3'b111, 1'b1, 32'h0, 32'h0, 1'b0);
        try_br("rsv_neg",   3'b111, 1'b0, 32'h0, 32'h8000_0000, 1'b0);
        set_br(3'b110, 1'b0, 32'h0, 32'h0, 16'h0777);
        valid_i = 1'b0;                           // invalid jump has no effect
        tick();
        idle();
        chk("inv_j_redirect", 32'(pc_redirect_o), 32'd0);
        chk("inv_j_flush",    32'(flush_o),       32'd0);
        chk("cond_count",     32'(taken_count_o), 32'(exp_count));

        // ---------------- branch inside squash window ignored ----------------
        set_br(3'b110, 1'b0, 32'h1, 32'h1, 16'h0100);   // J at t
        tick();                                   // t+1
        chk("j_redirect",  32'(pc_redirect_o), 32'd1);
        chk("j_target",    32'(pc_target_o),   32'h0100);
        exp_count++;
        set_br(3'b000, 1'b1, 32'h0, 32'h1, 16'h0200);   // BEQ taken at t+1, t+2
        regwrite_i = 1'b1;
        tick();                                   // t+2
        chk("ign_redirect2", 32'(pc_redirect_o), 32'd0);
        chk("ign_rw2",       32'(regwrite_o),    32'd0);
        tick();                                   // t+3
        idle();
        chk("ign_redirect3", 32'(pc_redirect_o), 32'd0);
        chk("ign_rw3",       32'(regwrite_o),    32'd0);
        chk("ign_target",    32'(pc_target_o),   32'h0100);
        chk("ign_count",     32'(taken_count_o), 32'(exp_count));
        tick();                                   // t+4
        chk("ign_flush4",    32'(flush_o),       32'd0);
        set_br(3'b000, 1'b1, 32'h0, 32'h1, 16'h0300);
        tick();                                   // t+5
        idle();
        chk("next_redirect", 32'(pc_redirect_o), 32'd1);
        chk("next_target",   32'(pc_target_o),   32'h0300);
        exp_count++;
        repeat (FD) tick();

        // ---------------- reset aborts a flush window ----------------
        set_br(3'b110, 1'b0, 32'h1, 32'h1, 16'h0044);
        tick();                                   // t+1
        idle();
        tick();                                   // t+2
        rst = 1'b1;
        valid_i = 1'b1; regwrite_i = 1'b1; rd_addr_i = 5'd5;
        tick();                                   // t+3
        chk("mid_rst_redirect", 32'(pc_redirect_o), 32'd0);
        chk("mid_rst_target",   32'(pc_target_o),   32'd0);
        chk("mid_rst_flush",    32'(flush_o),       32'd0);
        chk("mid_rst_count",    32'(taken_count_o), 32'd0);
        chk("mid_rst_rw",       32'(regwrite_o),    32'd0);
        chk("mid_rst_rd",       32'(rd_addr_o),     32'd0);
        rst = 1'b0;
        idle();
        set_br(3'b000, 1'b1, 32'h0, 32'h1, 16'h0088);
        tick();                                   // t+4
        idle();
        chk("post_rst_redirect", 32'(pc_redirect_o), 32'd1);
        chk("post_rst_target",   32'(pc_target_o),   32'h0088);
        chk("post_rst_count",    32'(taken_count_o), 32'd1);
        repeat (FD) tick();

        // ---------------- counter saturation ----------------
        force dut.r_taken_count = 16'hFFFD;
        #1;
        release dut.r_taken_count;
        tick();
        chk("sat_preload", 32'(taken_count_o), 32'hFFFD);
        try_br("sat_a", 3'b110, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("sat_cnt_a", 32'(taken_count_o), 32'hFFFE);
        try_br("sat_b", 3'b110, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("sat_cnt_b", 32'(taken_count_o), 32'hFFFF);
        try_br("sat_c", 3'b110, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("sat_cnt_c", 32'(taken_count_o), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(taken_count_o), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
